// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//   Shares the single read port of a synchronous FIFO among NUM_REQ consumers.
//   Round-robin arbitration with bounded bursts. The arbiter drives the FIFO read
//   request. Returning data is tagged with a one-hot valid for the issuing owner.
//   Optional feature macro: FIFO_ARB_STATS_EN adds a 32-bit total-read counter (rd_count_o).
module fifo_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_REQ-1:0]    rd_valid_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [31:0]           rd_count_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_W-1:0]     owner_r;
    logic [IDX_W-1:0]     owner_nxt_s;
    logic [IDX_W-1:0]     last_owner_r;
    logic [IDX_W-1:0]     last_owner_nxt_s;
    logic [IDX_W-1:0]     pick_s;
    logic [IDX_W-1:0]     cand_s;
    logic                 pick_found_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [NUM_REQ-1:0]   gnt_nxt_s;
    logic [NUM_REQ-1:0]   rd_valid_r;
    logic                 fifo_rd_s;

    // One-hot decode of a consumer index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] one_v;
        one_v = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one_v << idx;
    endfunction

    // Round-robin pick: first requester scanning upward from last_owner+1, wrapping.
    always_comb begin
        pick_s       = last_owner_r;
        pick_found_s = 1'b0;
        cand_s       = {IDX_W{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(last_owner_r) + i) % NUM_REQ);
            if (!pick_found_s && req_i[cand_s]) begin
                pick_s       = cand_s;
                pick_found_s = 1'b1;
            end else begin
                pick_s       = pick_s;
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state, grant and read-request decode.
    always_comb begin
        state_nxt_s      = state_r;
        owner_nxt_s      = owner_r;
        last_owner_nxt_s = last_owner_r;
        cnt_nxt_s        = cnt_r;
        gnt_nxt_s        = gnt_r;
        fifo_rd_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s && !fifo_empty_i) begin
                    owner_nxt_s = pick_s;
                    gnt_nxt_s   = onehot(pick_s);
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_BURST;
                end else begin
                    gnt_nxt_s   = {NUM_REQ{1'b0}};
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                // Never read from an empty FIFO, even on the exit cycle.
                fifo_rd_s = req_i[owner_r] & ~fifo_empty_i;
                if (fifo_rd_s) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                // The read on the exit cycle (MAX_BURST-th read) still counts.
                if (!req_i[owner_r] || fifo_empty_i || (fifo_rd_s && (cnt_r == LAST_CNT))) begin
                    state_nxt_s      = ST_IDLE;
                    gnt_nxt_s        = {NUM_REQ{1'b0}};
                    last_owner_nxt_s = owner_r;
                end else begin
                    state_nxt_s      = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // State, ownership, burst count and registered grant/valid.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            owner_r      <= {IDX_W{1'b0}};
            last_owner_r <= LAST_IDX;
            cnt_r        <= {CNT_W{1'b0}};
            gnt_r        <= {NUM_REQ{1'b0}};
            rd_valid_r   <= {NUM_REQ{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            owner_r      <= owner_nxt_s;
            last_owner_r <= last_owner_nxt_s;
            cnt_r        <= cnt_nxt_s;
            gnt_r        <= gnt_nxt_s;
            // Valid is tagged with the owner of the issuing cycle, not the next grant.
            rd_valid_r   <= fifo_rd_s ? onehot(owner_r) : {NUM_REQ{1'b0}};
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [31:0] rd_count_r;

    // Total reads issued; wraps naturally, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_count_r <= 32'd0;
        end else if (fifo_rd_s) begin
            rd_count_r <= rd_count_r + 32'd1;
        end else begin
            rd_count_r <= rd_count_r;
        end
    end

    assign rd_count_o = rd_count_r;
`else
    // Statistics counter not built in this configuration.
`endif

    assign gnt_o      = gnt_r;
    assign rd_valid_o = rd_valid_r;
    assign fifo_rd_o  = fifo_rd_s;
    assign rd_data_o  = fifo_data_i;

endmodule
